// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code controller:
// decoder state encoding, prefix bytes, discard list and the event record.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    localparam logic [7:0] PFX_E0   = 8'hE0;
    localparam logic [7:0] PFX_F0   = 8'hF0;
    localparam logic [7:0] PFX_E1   = 8'hE1;
    localparam logic [2:0] SKIP_LEN = 3'd7;
    localparam int         EVT_W    = 10;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    // Keyboard status/response bytes that never represent a key.
    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_E0) || (b == PFX_F0) || (b == PFX_E1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO; pointers wrap modulo FIFO_DEPTH (power of two),
// occupancy tracked by a separate count so full and empty are unambiguous.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [EVT_W-1:0] wdata,
    input  logic             pop,
    output logic [EVT_W-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a pop frees the slot a full-FIFO push needs.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 set-2 scan-code decoder feeding a show-ahead event FIFO.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make events.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    input  logic       evt_pop,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t           state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic             ovf_q, ovf_d;
    logic             push_req;
    logic             push;
    evt_t             evt_req;
    evt_t             head;
    logic [EVT_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        push_req = 1'b0;
        evt_req  = '0;
        if (rx_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PFX_E0) begin
                        state_d = ST_EXT;
                    end else if (rx_data == PFX_F0) begin
                        state_d = ST_BRK;
                    end else if (rx_data == PFX_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_LEN;
                    end else if (!is_discard(rx_data)) begin
                        push_req = 1'b1;
                        evt_req  = '{code: rx_data, ext: 1'b0, brk: 1'b0};
                    end
                end
                ST_EXT: begin
                    if (rx_data == PFX_F0) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != PFX_E0) begin
                        push_req = 1'b1;
                        evt_req  = '{code: rx_data, ext: 1'b1, brk: 1'b0};
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    // A prefix where a code belongs is a protocol error: drop it and resync.
                    state_d = ST_IDLE;
                    if (!is_prefix(rx_data)) begin
                        push_req = 1'b1;
                        evt_req  = '{code: rx_data, ext: (state_q == ST_EXT_BRK), brk: 1'b1};
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       flt_vld_q, flt_vld_d;
    logic [8:0] flt_key_q, flt_key_d;
    logic       key_match;

    assign key_match = flt_vld_q && (flt_key_q == {evt_req.code, evt_req.ext});
    assign push      = push_req && !(key_match && !evt_req.brk);

    always_comb begin
        flt_vld_d = flt_vld_q;
        flt_key_d = flt_key_q;
        if (push) begin
            if (!evt_req.brk) begin
                flt_vld_d = 1'b1;
                flt_key_d = {evt_req.code, evt_req.ext};
            end else if (key_match) begin
                flt_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_vld_q <= 1'b0;
            flt_key_q <= '0;
        end else begin
            flt_vld_q <= flt_vld_d;
            flt_key_q <= flt_key_d;
        end
    end
`else
    assign push = push_req;
`endif

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        // Setting wins over clearing so a drop in the clear cycle is not lost.
        if (push && fifo_full && !evt_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (evt_req),
        .pop   (evt_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields read as zero whenever nothing is queued.
    assign head      = (fifo_count != '0) ? evt_t'(fifo_rdata) : '0;
    assign evt_valid = !fifo_empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed self-checking bench for ps2_scancode_ctrl (FIFO_DEPTH = 4).
module tb_ps2_scancode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_pop = 1'b0;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    ps2_scancode_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_pop   (evt_pop),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pop_one;
        @(negedge clk);
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid); end
        total++; if (evt_code !== 8'h00) begin bad++; $display("FAIL reset_code got=%h want=00", evt_code); end
        total++; if ({evt_ext, evt_break} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {evt_ext, evt_break}); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_make;
        @(negedge clk);
        rx_data = 8'h1C; rx_ready = 1'b1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL make_early got=%b want=0", evt_valid); end
        @(negedge clk);
        rx_ready = 1'b0;
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL make_valid got=%b want=1", evt_valid); end
        total++; if ({evt_code, evt_ext, evt_break} !== {8'h1C, 2'b00}) begin bad++; $display("FAIL make_evt got=%h/%b%b want=1C/00", evt_code, evt_ext, evt_break); end
        pop_one();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL make_pop got=%b want=0", evt_valid); end
    endtask

    task automatic test_ext_break;
        send_byte(8'hE0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL extbrk_e0 got=%b want=0", evt_valid); end
        send_byte(8'hF0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL extbrk_f0 got=%b want=0", evt_valid); end
        send_byte(8'h75);
        total++; if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h75, 2'b11}) begin bad++; $display("FAIL extbrk_evt got=%b/%h/%b%b want=1/75/11", evt_valid, evt_code, evt_ext, evt_break); end
        pop_one();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL extbrk_single got=%b want=0", evt_valid); end
    endtask

    task automatic test_pause;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL pause_none got=%b want=0", evt_valid); end
        send_byte(8'h1C);
        total++; if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 2'b00}) begin bad++; $display("FAIL pause_after got=%b/%h/%b%b want=1/1C/00", evt_valid, evt_code, evt_ext, evt_break); end
        pop_one();
    endtask

    task automatic test_discard_and_ext;
        send_byte(8'hAA);
        send_byte(8'hFA);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL discard got=%b want=0", evt_valid); end
        send_byte(8'hE0);
        send_byte(8'hE0);
        send_byte(8'h74);
        total++; if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h74, 2'b10}) begin bad++; $display("FAIL ext_make got=%b/%h/%b%b want=1/74/10", evt_valid, evt_code, evt_ext, evt_break); end
        pop_one();
    endtask

    task automatic test_protocol_error;
        send_byte(8'hF0);
        send_byte(8'hE0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL proterr_none got=%b want=0", evt_valid); end
        send_byte(8'h1C);
        total++; if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 2'b00}) begin bad++; $display("FAIL proterr_resync got=%b/%h/%b%b want=1/1C/00", evt_valid, evt_code, evt_ext, evt_break); end
        pop_one();
    endtask

    task automatic test_overflow;
        logic [7:0] codes [6] = '{8'h15, 8'h1D, 8'h1E, 8'h21, 8'h22, 8'h23};
        for (int i = 0; i < 4; i++) send_byte(codes[i]);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_at_full got=%b want=0", overflow); end
        send_byte(codes[4]);
        send_byte(codes[5]);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({evt_valid, evt_code} !== {1'b1, codes[i]}) begin bad++; $display("FAIL ovf_pop%0d got=%b/%h want=1/%h", i, evt_valid, evt_code, codes[i]); end
            pop_one();
        end
        total++; if ({evt_valid, evt_code} !== 9'h000) begin bad++; $display("FAIL ovf_empty got=%b/%h want=0/00", evt_valid, evt_code); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp [4] = '{8'h1D, 8'h1E, 8'h21, 8'h2B};
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h1E); send_byte(8'h21);
        @(negedge clk);
        rx_data = 8'h2B; rx_ready = 1'b1; evt_pop = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; evt_pop = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%b want=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({evt_valid, evt_code} !== {1'b1, exp[i]}) begin bad++; $display("FAIL fullpp_pop%0d got=%b/%h want=1/%h", i, evt_valid, evt_code, exp[i]); end
            pop_one();
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL fullpp_empty got=%b want=0", evt_valid); end
    endtask

    task automatic test_ovf_clr_collision;
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h1E); send_byte(8'h21);
        @(negedge clk);
        rx_data = 8'h22; rx_ready = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; ovf_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%b want=1", overflow); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        repeat (4) pop_one();
        total++; if ({evt_valid, overflow} !== 2'b00) begin bad++; $display("FAIL clr_drain got=%b want=00", {evt_valid, overflow}); end
    endtask

    task automatic test_empty_push_pop;
        @(negedge clk);
        rx_data = 8'h1C; rx_ready = 1'b1; evt_pop = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; evt_pop = 1'b0;
        total++; if ({evt_valid, evt_code} !== {1'b1, 8'h1C}) begin bad++; $display("FAIL emptypp got=%b/%h want=1/1C", evt_valid, evt_code); end
        pop_one();
    endtask

    task automatic test_reset_mid;
        send_byte(8'hE0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h1C);
        total++; if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 2'b00}) begin bad++; $display("FAIL rstmid got=%b/%h/%b%b want=1/1C/00", evt_valid, evt_code, evt_ext, evt_break); end
        pop_one();
    endtask

    task automatic test_typematic;
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_TYPEMATIC_FILTER_EN
        logic       vexp [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic       vexp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        logic       bexp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int         nev = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i]);
            total++;
            if (evt_valid !== vexp[i]) begin
                bad++; $display("FAIL typ_valid%0d got=%b want=%b", i, evt_valid, vexp[i]);
            end else if (vexp[i] && ({evt_code, evt_ext, evt_break} !== {8'h1C, 1'b0, bexp[i]})) begin
                bad++; $display("FAIL typ_evt%0d got=%h/%b%b want=1C/0%b", i, evt_code, evt_ext, evt_break, bexp[i]);
            end
            if (evt_valid) begin nev++; pop_one(); end
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        total++; if (nev != 3) begin bad++; $display("FAIL typ_count got=%0d want=3", nev); end
`else
        total++; if (nev != 5) begin bad++; $display("FAIL typ_count got=%0d want=5", nev); end
`endif
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_pause();
        test_discard_and_ext();
        test_protocol_error();
        test_overflow();
        test_full_push_pop();
        test_ovf_clr_collision();
        test_empty_push_pop();
        test_reset_mid();
        test_typematic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
